seg7_scan: RTL and testbench

SEG7_SCAN -- requirements
Module: seg7_scan

---
 rtl/seg7_pkg.sv | 18 +
 rtl/seg7_decode.sv | 17 +
 rtl/seg7_scan.sv | 102 ++++++++++
 tb/tb_seg7_scan.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed seven-segment scanner: segment table,
// blank/idle drive values and the digit count.
package seg7_pkg;

    localparam int unsigned DIGIT_COUNT = 8;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [7:0] EN_NONE   = 8'hFF;

    typedef logic [2:0] digit_idx_t;

    // Active-low segments, bit 0 = a ... bit 6 = g, indexed by hex value.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to active-low seven-segment decoder with a blank override.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_TABLE[nibble];
        if (blank) begin
            seg = SEG_BLANK;
        end
    end

endmodule

// File: rtl/seg7_scan.sv
// Eight-digit multiplexed seven-segment scanner with a CPU-writable shadow register,
// frame-synchronous display update and optional leading-zero blanking.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 1000,
    parameter int unsigned NUM_DIGITS = 8
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   wr_en,
    input  logic [31:0]            wr_data,
    input  logic                   blank_lz,
    output logic [6:0]             out7,
    output logic [DIGIT_COUNT-1:0] en_out,
    output logic                   frame_done
);

    localparam int unsigned PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);
    localparam digit_idx_t IDX_LAST = digit_idx_t'(NUM_DIGITS - 1);

    logic [PRE_W-1:0]       presc_q, presc_d;
    digit_idx_t             idx_q, idx_d;
    logic [31:0]            shadow_q, shadow_d;
    logic [31:0]            disp_q, disp_d;
    logic [6:0]             out7_q;
    logic [DIGIT_COUNT-1:0] en_q, en_d;
    logic                   frame_done_q;

    logic                   tick;
    logic                   wrap;
    logic                   zero_run;
    logic [DIGIT_COUNT-1:0] lz_zero;
    logic [3:0]             cur_nib;
    logic                   blank_digit;
    logic [6:0]             seg;

    always_comb begin
        tick     = (presc_q == PRE_LAST);
        wrap     = tick && (idx_q == IDX_LAST);
        presc_d  = tick ? '0 : presc_q + 1'b1;
        idx_d    = tick ? idx_q + 1'b1 : idx_q;
        shadow_d = wr_en ? wr_data : shadow_q;
        // Display only follows the shadow at the frame boundary so a frame never tears.
        disp_d   = wrap ? shadow_q : disp_q;
    end

    // lz_zero[k] is set when nibbles k..7 of the display are all zero.
    always_comb begin
        zero_run = 1'b1;
        lz_zero  = '0;
        for (int k = DIGIT_COUNT - 1; k >= 0; k--) begin
            zero_run   = zero_run & (disp_q[4*k +: 4] == 4'h0);
            lz_zero[k] = zero_run;
        end
    end

    always_comb begin
        cur_nib     = disp_q[{idx_q, 2'b00} +: 4];
        blank_digit = blank_lz && (idx_q != '0) && lz_zero[idx_q];
        en_d        = EN_NONE;
        en_d[idx_q] = 1'b0;
    end

    seg7_decode u_decode (
        .nibble (cur_nib),
        .blank  (blank_digit),
        .seg    (seg)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            presc_q  <= '0;
            idx_q    <= '0;
            shadow_q <= '0;
            disp_q   <= '0;
        end else begin
            presc_q  <= presc_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            disp_q   <= disp_d;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            out7_q       <= SEG_BLANK;
            en_q         <= EN_NONE;
            frame_done_q <= 1'b0;
        end else begin
            out7_q       <= seg;
            en_q         <= en_d;
            frame_done_q <= wrap;
        end
    end

    assign out7       = out7_q;
    assign en_out     = en_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Scoreboard bench for seg7_scan at CLK_DIV=4: expected digits are queued by the
// stimulus and consumed by a monitor on every new digit strobe.
module tb_seg7_scan;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        blank_lz;
    logic [6:0]  out7;
    logic [7:0]  en_out;
    logic        frame_done;

    always #5 Clk = ~Clk;

    seg7_scan #(
        .CLK_DIV    (4),
        .NUM_DIGITS (8)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .blank_lz   (blank_lz),
        .out7       (out7),
        .en_out     (en_out),
        .frame_done (frame_done)
    );

    typedef struct packed {
        logic [7:0] en;
        logic [6:0] seg;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic push_dig(input logic [7:0] en, input logic [6:0] seg);
        exp_t e;
        e.en  = en;
        e.seg = seg;
        sb_q.push_back(e);
    endtask

    task automatic push8(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                         input logic [6:0] s3, input logic [6:0] s4, input logic [6:0] s5,
                         input logic [6:0] s6, input logic [6:0] s7);
        logic [6:0] s [8];
        logic [7:0] en;
        s = '{s0, s1, s2, s3, s4, s5, s6, s7};
        for (int k = 0; k < 8; k++) begin
            en    = 8'hFF;
            en[k] = 1'b0;
            push_dig(en, s[k]);
        end
    endtask

    // Returns the number of cycles until frame_done is seen high.
    task automatic wait_frame(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!frame_done && n < 100);
        if (!frame_done) begin
            n_tests++;
            n_fail++;
            $display("FAIL frame_timeout: got no frame_done in %0d cycles, expected one", n);
        end
    endtask

    task automatic monitor();
        logic [7:0] prev_en;
        int         cyc;
        int         last;
        exp_t       e;
        prev_en = 8'hFF;
        cyc     = 0;
        last    = 0;
        forever begin
            @(negedge Clk);
            cyc++;
            if (en_out !== prev_en && en_out !== 8'hFF) begin
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    n_tests++;
                    if (en_out !== e.en || out7 !== e.seg ||
                        (prev_en !== 8'hFF && cyc - last != 4)) begin
                        n_fail++;
                        $display("FAIL digit: got en=%h seg=%h dwell=%0d, expected en=%h seg=%h dwell=4",
                                 en_out, out7, cyc - last, e.en, e.seg);
                    end
                end
                last = cyc;
            end
            prev_en = en_out;
        end
    endtask

    int n;

    initial begin
        Reset    = 1'b0;
        wr_en    = 1'b0;
        wr_data  = '0;
        blank_lz = 1'b1;
        fork
            monitor();
        join_none

        // Reset state and first edge after release
        ticks(3);
        check("rst_out7", 32'(out7), 32'h7F);
        check("rst_en", 32'(en_out), 32'hFF);
        check("rst_fd", 32'(frame_done), 32'h0);
        push8(7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
        #1 Reset = 1'b1;
        tick();
        check("first_out7", 32'(out7), 32'h40);
        check("first_en", 32'(en_out), 32'hFE);
        wait_frame(n);
        check("first_frame_gap", n, 31);
        check("q_empty_rst", sb_q.size(), 0);

        // 0x000000A5 with and without leading-zero blanking
        wr_en = 1'b1; wr_data = 32'h0000_00A5;
        tick();
        wr_en = 1'b0;
        wait_frame(n);
        push8(7'h12, 7'h08, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
        wait_frame(n);
        check("q_empty_a5_blank", sb_q.size(), 0);
        blank_lz = 1'b0;
        push8(7'h12, 7'h08, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40);
        wait_frame(n);
        check("q_empty_a5_noblank", sb_q.size(), 0);

        // Write on the wrap edge lands one frame late
        wr_en = 1'b1; wr_data = 32'h1234_5678;
        tick();
        wr_en = 1'b0;
        ticks(30);
        wr_en = 1'b1; wr_data = 32'hFFFF_FFFF;
        tick();
        wr_en = 1'b0;
        check("wrap_fd", 32'(frame_done), 32'h1);
        push8(7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79);
        wait_frame(n);
        check("period_a", n, 32);
        push8(7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E);
        wait_frame(n);
        check("period_b", n, 32);
        check("q_empty_wrap", sb_q.size(), 0);

        // All-zero value with blanking shows a single 0
        blank_lz = 1'b1;
        wr_en = 1'b1; wr_data = 32'h0;
        tick();
        wr_en = 1'b0;
        wait_frame(n);
        push8(7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
        wait_frame(n);
        check("q_empty_zero", sb_q.size(), 0);

        // Reset during digit 3 of 0xDEADBEEF with a pending shadow write
        wr_en = 1'b1; wr_data = 32'hDEAD_BEEF;
        tick();
        wr_en = 1'b0;
        wait_frame(n);
        push_dig(8'hFE, 7'h0E);
        push_dig(8'hFD, 7'h06);
        push_dig(8'hFB, 7'h06);
        push_dig(8'hF7, 7'h03);
        wr_en = 1'b1; wr_data = 32'h1111_1111;
        tick();
        wr_en = 1'b0;
        ticks(13);
        check("pre_rst_en", 32'(en_out), 32'hF7);
        #1 Reset = 1'b0;
        #1;
        check("midrst_out7", 32'(out7), 32'h7F);
        check("midrst_en", 32'(en_out), 32'hFF);
        check("midrst_fd", 32'(frame_done), 32'h0);
        check("q_empty_midrst", sb_q.size(), 0);
        ticks(3);
        check("midrst_hold_en", 32'(en_out), 32'hFF);
        push8(7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
        push8(7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
        #1 Reset = 1'b1;
        tick();
        check("rerel_out7", 32'(out7), 32'h40);
        check("rerel_en", 32'(en_out), 32'hFE);
        wait_frame(n);
        check("rerel_frame_gap", n, 31);
        wait_frame(n);
        check("rerel_period", n, 32);
        check("q_empty_final", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
